// File: rtl/amber_wb_inst_feeder.sv
// amber_wb_inst_feeder: Wishbone slave feeding FIFO'd instruction words to the core and capturing its stores.
module amber_wb_inst_feeder #(
  parameter int          DEPTH    = 8,
  parameter int          ACK_LAT  = 1,
  parameter logic [31:0] NOP_WORD = 32'hE1A00000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_valid,
  input  logic [31:0]                inst_data,
  output logic                       inst_ready,
  input  logic [31:0]                i_wb_adr,
  input  logic [15:0]                i_wb_sel,
  input  logic                       i_wb_we,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  input  logic [127:0]               i_wb_dat,
  output logic [127:0]               o_wb_dat,
  output logic                       o_wb_ack,
  output logic                       o_wb_err,
  output logic                       st_valid,
  output logic [31:0]                st_adr,
  output logic [31:0]                st_dat,
  output logic [3:0]                 st_sel,
  output logic                       empty_fetch,
  output logic [15:0]                fetch_cnt,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   adr_q;
  logic          we_q;
  logic [15:0]   sel_q;
  logic [127:0]  dat_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic          req, take, resp, ok, rd, wr, push, pop, fifo_empty;
  logic [1:0]    lane;
  assign req        = i_wb_cyc & i_wb_stb;
  assign take       = (state_q == IDLE) & req;
  assign resp       = state_q == RESP;
  assign ok         = resp & (adr_q[1:0] == 2'b00);
  assign rd         = ok & !we_q;
  assign wr         = ok & we_q;
  assign lane       = adr_q[3:2];
  assign fifo_empty = level_q == '0;
  // Pop uses the pre-push occupancy, so a word pushed into an empty FIFO is never bypassed to the reader.
  assign pop        = rd & !fifo_empty;
  assign inst_ready = !rst & (level_q != (AW+1)'(DEPTH));
  assign push       = inst_valid & inst_ready;
  assign level      = level_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (take) begin
      state_d = (ACK_LAT == 0) ? RESP : WAIT;
      cnt_d   = 3'(ACK_LAT);
    end else if (state_q == WAIT) begin
      state_d = !i_wb_cyc ? IDLE : (cnt_q == 3'd1 ? RESP : WAIT);
      cnt_d   = cnt_q - 3'd1;
    end else if (resp) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= inst_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      dat_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      level_q     <= '0;
      o_wb_dat    <= '0;
      o_wb_ack    <= 1'b0;
      o_wb_err    <= 1'b0;
      st_valid    <= 1'b0;
      st_adr      <= '0;
      st_dat      <= '0;
      st_sel      <= '0;
      empty_fetch <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        adr_q <= i_wb_adr;
        we_q  <= i_wb_we;
        sel_q <= i_wb_sel;
        dat_q <= i_wb_dat;
      end
      o_wb_ack    <= ok;
      o_wb_err    <= resp & (adr_q[1:0] != 2'b00);
      o_wb_dat    <= rd ? (128'(fifo_empty ? NOP_WORD : mem_q[rd_q]) << (32 * lane)) : '0;
      empty_fetch <= rd & fifo_empty;
      fetch_cnt   <= fetch_cnt + 16'(rd);
      st_valid    <= wr;
      if (wr) begin
        st_adr <= adr_q;
        st_dat <= dat_q[32*lane +: 32];
        st_sel <= sel_q[4*lane +: 4];
      end
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      level_q <= level_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_amber_wb_inst_feeder.sv
// tb_amber_wb_inst_feeder: directed plus randomized checks of the feeder against a queue-based reference model.
module tb_amber_wb_inst_feeder;
  localparam int          DEPTH = 8;
  localparam int          LAT   = 3;
  localparam logic [31:0] NOP   = 32'hE1A00000;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inst_valid = 1'b0;
  logic [31:0]  inst_data = '0;
  logic         inst_ready;
  logic [31:0]  i_wb_adr = '0;
  logic [15:0]  i_wb_sel = '0;
  logic         i_wb_we = 1'b0;
  logic         i_wb_cyc = 1'b0;
  logic         i_wb_stb = 1'b0;
  logic [127:0] i_wb_dat = '0;
  logic [127:0] o_wb_dat;
  logic         o_wb_ack, o_wb_err, st_valid, empty_fetch;
  logic [31:0]  st_adr, st_dat;
  logic [3:0]   st_sel;
  logic [15:0]  fetch_cnt;
  logic [$clog2(DEPTH):0] level;
  int           errors = 0;
  int           checks = 0;
  logic [31:0]  q [$];
  logic [15:0]  fcnt = '0;

  amber_wb_inst_feeder #(.DEPTH(DEPTH), .ACK_LAT(LAT), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_data(inst_data), .inst_ready(inst_ready),
    .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .i_wb_dat(i_wb_dat), .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .st_valid(st_valid), .st_adr(st_adr), .st_dat(st_dat), .st_sel(st_sel),
    .empty_fetch(empty_fetch), .fetch_cnt(fetch_cnt), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    logic seen;
    seen = 1'b0;
    rst = 1'b1;
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    inst_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= o_wb_ack | o_wb_err;
    end
    check("rst_no_ack", seen, 0);
    check("rst_dat", o_wb_dat, 0);
    check("rst_pulses", {o_wb_ack, o_wb_err, st_valid, empty_fetch}, 0);
    check("rst_st", {st_adr, st_dat, st_sel}, 0);
    check("rst_fcnt", fetch_cnt, 0);
    check("rst_level", level, 0);
    check("rst_ready", inst_ready, 0);
    rst = 1'b0;
    q.delete();
    fcnt = '0;
    @(negedge clk);
    check("post_rst_ready", inst_ready, 1);
    check("post_rst_level", level, 0);
  endtask

  task automatic push(input logic [31:0] w);
    logic acc;
    acc = q.size() < DEPTH;
    inst_valid = 1'b1;
    inst_data = w;
    check("push_ready", inst_ready, acc);
    @(posedge clk);
    #1 inst_valid = 1'b0;
    if (acc) q.push_back(w);
    @(negedge clk);
    check("push_level", level, q.size());
  endtask

  task automatic wb(input logic [31:0] adr, input logic we, input logic [15:0] sel, input logic [127:0] dat);
    logic mis, e_empty, early;
    logic [1:0] lane;
    logic [31:0] word;
    logic [127:0] e_dat;
    mis = adr[1:0] != 2'b00;
    lane = adr[3:2];
    e_dat = '0;
    e_empty = 1'b0;
    early = 1'b0;
    if (!mis && !we) begin
      e_empty = q.size() == 0;
      word = e_empty ? NOP : q.pop_front();
      e_dat = 128'(word) << (32 * lane);
      fcnt++;
    end
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_adr = adr;
    i_wb_we = we;
    i_wb_sel = sel;
    i_wb_dat = dat;
    @(posedge clk);
    #1 i_wb_stb = 1'b0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      early |= o_wb_ack | o_wb_err | st_valid | empty_fetch | (|o_wb_dat);
    end
    @(negedge clk);
    check("early_resp", early, 0);
    check("ack", o_wb_ack, !mis);
    check("err", o_wb_err, mis);
    check("rdata", o_wb_dat, e_dat);
    check("empty_fetch", empty_fetch, e_empty);
    check("st_valid", st_valid, we && !mis);
    if (we && !mis) begin
      check("st_adr", st_adr, adr);
      check("st_dat", st_dat, dat[32*lane +: 32]);
      check("st_sel", st_sel, sel[4*lane +: 4]);
    end
    check("fetch_cnt", fetch_cnt, fcnt);
    check("level", level, q.size());
    i_wb_cyc = 1'b0;
    @(negedge clk);
    check("pulse_width", {o_wb_ack, o_wb_err, st_valid, empty_fetch, |o_wb_dat}, 0);
  endtask

  task automatic abort_req(input logic [31:0] adr);
    logic seen;
    seen = 1'b0;
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_adr = adr;
    i_wb_we = 1'($urandom);
    @(posedge clk);
    #1 i_wb_stb = 1'b0;
    @(posedge clk);
    #1 i_wb_cyc = 1'b0;
    repeat (LAT + 3) begin
      @(negedge clk);
      seen |= o_wb_ack | o_wb_err | st_valid | empty_fetch;
    end
    check("abort_resp", seen, 0);
    check("abort_level", level, q.size());
    check("abort_fcnt", fetch_cnt, fcnt);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] held;
    do_reset();
    push(32'hE3A01005);
    push(32'hE2811001);
    wb(32'h0, 1'b0, 16'hFFFF, '0);
    wb(32'h4, 1'b0, 16'hFFFF, '0);
    wb(32'h8, 1'b0, 16'hFFFF, '0);
    wb(32'h100C, 1'b1, 16'hF000, {32'hDEADBEEF, 96'h0});
    for (int i = 0; i < DEPTH; i++) push($urandom);
    check("full_ready", inst_ready, 0);
    check("full_level", level, DEPTH);
    held = $urandom;
    inst_valid = 1'b1;
    inst_data = held;
    wb(32'h0, 1'b0, 16'hFFFF, '0);
    q.push_back(held);
    inst_valid = 1'b0;
    check("held_push_level", level, DEPTH);
    do_reset();
    push(32'h12345678);
    wb(32'h2, 1'b0, 16'hFFFF, '0);
    abort_req(32'h4);
    wb(32'h4, 1'b0, 16'hFFFF, '0);
    push(32'hCAFEF00D);
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_adr = 32'h0;
    i_wb_we = 1'b0;
    @(posedge clk);
    #1 i_wb_stb = 1'b0;
    @(posedge clk);
    #1 do_reset();
    for (int i = 0; i < 120; i++) begin
      int op;
      op = $urandom_range(0, 9);
      a = $urandom;
      a[1:0] = 2'b00;
      if (op <= 3) push($urandom);
      else if (op <= 6) wb(a, 1'b0, 16'($urandom), '0);
      else if (op == 7) wb(a, 1'b1, 16'($urandom), {$urandom, $urandom, $urandom, $urandom});
      else if (op == 8) wb(a | 32'($urandom_range(1, 3)), 1'($urandom), 16'($urandom), {$urandom, $urandom, $urandom, $urandom});
      else abort_req(a);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
